smul_ctrl: RTL and testbench
============================

# smul_ctrl

Sequencing controller for the `smul` sub-MAC multiplier chain. It accepts one command at a time: precision, chain mode and beat count. For each command it:
- drives the chain's `ce`, `select_precision`, `active_chain` and `sclr` controls;
- meters operand beats in through a valid/ready handshake;
- tracks the fixed multiplier pipeline latency, so each result beat leaving `res_mac_next` carries `res_valid`/`res_last` under downstream backpressure.

It sits between the operand/weight buffers and the accumulator stage of the DTPU datapath.

## Interface
Parameters:
- `MUL_LATENCY`, default 3: register stages from operand capture to `res_mac_next`. Legal range 1..8.
- `CNT_W`, default 16: width of the beat counter and `cmd_len`.

Ports:
- `clk`  in  1  single clock for the block.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_prec`  in  2  precision code: 00 INT8, 01 INT16, 10 INT32, 11 ALL.
- `cmd_chain`  in  1  accumulate through the PCOUT chain.
- `cmd_len`  in  CNT_W  number of operand beats; 0 is legal.
- `in_valid`  in  1  operand/weight beat available.
- `in_ready`  out  1  beat captured by the multipliers this cycle.
- `res_ready`  in  1  downstream accepts a result beat.
- `res_valid`  out  1  `res_mac_next` holds a valid product.
- `res_last`  out  1  final result beat of the command.
- `ce`  out  1  chain clock enable.
- `select_precision`  out  4  one-hot-group lane enables.
- `active_chain`  out  1  chain propagate enable.
- `sclr`  out  1  synchronous clear of the chain.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when a command completes.

## Operation
- **States:** IDLE, CLEAR, RUN, DRAIN, DONE.
- **Command accept:** occurs when `cmd_valid & cmd_ready`.
  - Latch `cmd_prec`, `cmd_chain` and `cmd_len` into `remaining`.
- **Transition out of IDLE** (priority in this order):
  - `cmd_len==0` goes to DONE. No clear is issued and no beats are taken.
  - Otherwise, if `cmd_prec` differs from the last executed precision, or `cmd_chain=1`, or no command has run since reset, go to CLEAR.
  - Otherwise go to RUN.
- **CLEAR:** lasts exactly 1 cycle with `sclr=1` and `ce=0`; the pipeline is empty. Then go to RUN.
- **Precision decode:** INT8 gives `select_precision=4'b0011`, INT16 gives `4'b0100`, INT32 gives `4'b1000`, ALL gives `4'b1111`.
  - Driven in CLEAR, RUN and DRAIN; 0 in IDLE and DONE.
- **`active_chain`:** equals the latched `cmd_chain` in CLEAR, RUN and DRAIN; 0 otherwise.
- **Valid pipe:** `vpipe[MUL_LATENCY-1:0]` plus a parallel `lpipe` for the last flag.
  - Advance condition: `adv = (RUN|DRAIN) & (!vpipe[L-1] | res_ready)`.
  - `ce = adv`. With `ce=0` the DSPs and both pipes freeze.
  - `in_ready = RUN & adv`.
  - On `adv`, shift in `acc = in_valid & in_ready` and `acc & (remaining==1)`.
  - `res_valid = vpipe[L-1]`; `res_last = lpipe[L-1]`.
- **RUN:** each accepted beat decrements `remaining`. When the accepted beat has `remaining==1`, go to DRAIN.
  - Bubbles (`in_valid=0`) shift zeros and are never counted.
- **DRAIN:** `in_ready=0`. When all `vpipe` bits are 0, go to DONE.
- **DONE:** `done=1` for 1 cycle, record last precision, then go to IDLE.
- **Reset**, at any time including mid-command:
  - State goes to IDLE and `vpipe`, `lpipe` and `remaining` clear.
  - The last-precision-valid flag clears.
  - Outputs reset as follows: `cmd_ready=1`; all other outputs 0.
- `cmd_valid` is ignored outside IDLE. Command fields are sampled only on accept.

## Timing
- Accepting at cycle 0 with clear: CLEAR in cycle 1, first `in_ready` in cycle 2.
- Accepting at cycle 0 without clear: first `in_ready` in cycle 1.
- A beat accepted at cycle t gives `res_valid` at t+MUL_LATENCY when no stall occurs. Each cycle of `res_ready=0` with `res_valid=1` adds one cycle.
- `done` asserts the cycle after the last result beat is consumed. `cmd_ready` returns the cycle after that.
- N beats, no stalls, no clear: accept at 0, `done` at N+MUL_LATENCY+1.
- All outputs are registered or decoded from state and pipe registers only. There is no combinational path from `res_ready`/`in_valid` to `cmd_ready`.

## Structure
- Precision codes, the decode to `select_precision`, and the state encoding go in the shared `precision_def.vh`.
- One sub-module, `smul_valid_pipe`: an enable-gated, MUL_LATENCY-deep shift register carrying the {valid,last} pair, with an `empty` output.

## Test plan
- **INT8, len=4, no stalls, L=3, first command:** `sclr` pulses at cycle 1, `in_ready` spans cycles 2-5, `res_valid` spans cycles 5-8 with `res_last` at cycle 8, `done` at cycle 9, `select_precision=0011`.
- **Second INT8 command, len=2, `cmd_chain=0`:** no CLEAR cycle; first `in_ready` one cycle after accept.
- **INT32, len=3, `res_ready` low for 2 cycles while the first result is valid:** `ce=0` for exactly those cycles; `res_valid` stays high; all 3 results delivered; `done` delayed by 2 cycles.
- **len=0:** `done` one cycle after accept; `sclr`, `ce` and `in_ready` never assert.
- **ALL, len=5, `in_valid` toggling 1,0,1,0…:** exactly 5 beats counted, `res_valid` gaps match input gaps, `res_last` only on the fifth result.
- **`rst` asserted in RUN with 2 beats in flight:** the following cycle shows IDLE with `busy=0`, `res_valid=0`, `ce=0`; the next command forces CLEAR even with the same precision.

Source files
------------

// File: rtl/smul_ctrl_pkg.sv
// Shared definitions for the smul chain sequencer: FSM states, precision
// codes and the precision-to-lane-enable decode.
package smul_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam logic [1:0] PREC_INT8  = 2'b00;
    localparam logic [1:0] PREC_INT16 = 2'b01;
    localparam logic [1:0] PREC_INT32 = 2'b10;
    localparam logic [1:0] PREC_ALL   = 2'b11;

    localparam logic [3:0] SEL_NONE = 4'b0000;

    // INT8 packs two products per DSP, hence two lane enables.
    function automatic logic [3:0] prec_decode(input logic [1:0] prec);
        logic [3:0] sel;
        case (prec)
            PREC_INT8:  sel = 4'b0011;
            PREC_INT16: sel = 4'b0100;
            PREC_INT32: sel = 4'b1000;
            PREC_ALL:   sel = 4'b1111;
            default:    sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/smul_valid_pipe.sv
// Enable-gated shift register that shadows the multiplier pipeline with a
// {valid,last} pair per stage.
module smul_valid_pipe #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic valid_i,
    input  logic last_i,
    output logic valid_o,
    output logic last_o,
    output logic empty_o
);

    logic [DEPTH-1:0] vpipe_q;
    logic [DEPTH-1:0] lpipe_q;
    logic [DEPTH-1:0] vpipe_d;
    logic [DEPTH-1:0] lpipe_d;

    // Next pipe contents: shift one stage when enabled, otherwise hold.
    always_comb begin
        vpipe_d = vpipe_q;
        lpipe_d = lpipe_q;
        if (en_i) begin
            vpipe_d    = vpipe_q << 1;
            lpipe_d    = lpipe_q << 1;
            vpipe_d[0] = valid_i;
            lpipe_d[0] = last_i;
        end else begin
            vpipe_d = vpipe_q;
            lpipe_d = lpipe_q;
        end
    end

    // Pipe registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vpipe_q <= '0;
            lpipe_q <= '0;
        end else begin
            vpipe_q <= vpipe_d;
            lpipe_q <= lpipe_d;
        end
    end

    assign valid_o = vpipe_q[DEPTH-1];
    assign last_o  = lpipe_q[DEPTH-1];
    // Looks one edge ahead so the drain ends right as the last beat leaves.
    assign empty_o = (vpipe_d == '0);

endmodule

// File: rtl/smul_ctrl.sv
// Sequencing controller for the smul sub-MAC multiplier chain: accepts one
// command at a time, meters operand beats and tags results under backpressure.
module smul_ctrl
    import smul_ctrl_pkg::*;
#(
    parameter int MUL_LATENCY = 3,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_prec,
    input  logic             cmd_chain,
    input  logic [CNT_W-1:0] cmd_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             res_ready,
    output logic             res_valid,
    output logic             res_last,
    output logic             ce,
    output logic [3:0]       select_precision,
    output logic             active_chain,
    output logic             sclr,
    output logic             busy,
    output logic             done
);

    state_e           state_q;
    logic [1:0]       prec_q;
    logic             chain_q;
    logic [CNT_W-1:0] remaining_q;
    logic [1:0]       last_prec_q;
    logic             last_prec_vld_q;

    logic run_s;
    logic drain_s;
    logic active_s;
    logic adv_s;
    logic in_ready_s;
    logic acc_s;
    logic last_beat_s;
    logic pipe_valid_s;
    logic pipe_last_s;
    logic pipe_empty_s;

    assign run_s       = (state_q == ST_RUN);
    assign drain_s     = (state_q == ST_DRAIN);
    assign active_s    = (state_q == ST_CLEAR) | run_s | drain_s;
    assign adv_s       = (run_s | drain_s) & (~pipe_valid_s | res_ready);
    assign in_ready_s  = run_s & adv_s;
    assign acc_s       = in_valid & in_ready_s;
    assign last_beat_s = acc_s & (remaining_q == CNT_W'(1));

    smul_valid_pipe #(
        .DEPTH (MUL_LATENCY)
    ) u_valid_pipe (
        .clk     (clk),
        .rst     (rst),
        .en_i    (adv_s),
        .valid_i (acc_s),
        .last_i  (last_beat_s),
        .valid_o (pipe_valid_s),
        .last_o  (pipe_last_s),
        .empty_o (pipe_empty_s)
    );

    // Command sequencing FSM with latched command fields and precision history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            prec_q          <= 2'b00;
            chain_q         <= 1'b0;
            remaining_q     <= '0;
            last_prec_q     <= 2'b00;
            last_prec_vld_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        prec_q      <= cmd_prec;
                        chain_q     <= cmd_chain;
                        remaining_q <= cmd_len;
                        if (cmd_len == '0) begin
                            state_q <= ST_DONE;
                        end else if (!last_prec_vld_q || (cmd_prec != last_prec_q) || cmd_chain) begin
                            state_q <= ST_CLEAR;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_CLEAR: begin
                    state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (acc_s) begin
                        remaining_q <= remaining_q - CNT_W'(1);
                        if (last_beat_s) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pipe_empty_s) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    last_prec_q     <= prec_q;
                    last_prec_vld_q <= 1'b1;
                    state_q         <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready        = (state_q == ST_IDLE);
    assign busy             = (state_q != ST_IDLE);
    assign done             = (state_q == ST_DONE);
    assign sclr             = (state_q == ST_CLEAR);
    assign ce               = adv_s;
    assign in_ready         = in_ready_s;
    assign res_valid        = pipe_valid_s;
    assign res_last         = pipe_last_s;
    assign select_precision = active_s ? prec_decode(prec_q) : SEL_NONE;
    assign active_chain     = active_s & chain_q;

endmodule

// File: tb/tb_smul_ctrl.sv
// Randomized self-checking bench for smul_ctrl against a queue-based
// reference of in-flight beats and command timing.
module tb_smul_ctrl;

    localparam int L  = 3;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_prec = 2'b00;
    logic          cmd_chain = 1'b0;
    logic [CW-1:0] cmd_len = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          res_ready = 1'b0;
    logic          res_valid;
    logic          res_last;
    logic          ce;
    logic [3:0]    select_precision;
    logic          active_chain;
    logic          sclr;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    smul_ctrl #(.MUL_LATENCY(L), .CNT_W(CW)) dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_prec         (cmd_prec),
        .cmd_chain        (cmd_chain),
        .cmd_len          (cmd_len),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .res_ready        (res_ready),
        .res_valid        (res_valid),
        .res_last         (res_last),
        .ce               (ce),
        .select_precision (select_precision),
        .active_chain     (active_chain),
        .sclr             (sclr),
        .busy             (busy),
        .done             (done)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc = -1;
    int stalls  = 0;

    // Reference: command phase flags plus a list of in-flight beats, each
    // holding how many more pipeline advances it needs to reach the output.
    bit         m_active = 1'b0;
    bit         m_clear  = 1'b0;
    bit         m_done   = 1'b0;
    bit         m_chain  = 1'b0;
    bit         m_last_vld = 1'b0;
    logic [1:0] m_prec = 2'b00;
    logic [1:0] m_last_prec = 2'b00;
    int         m_left = 0;
    int         fl_cnt[$];
    bit         fl_last[$];
    logic [3:0] sel_tab [4] = '{4'b0011, 4'b0100, 4'b1000, 4'b1111};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input bit cv, input logic [1:0] cp, input bit cc, input int cl,
                        input int ivm, input int rrm, input bit do_rst);
        bit idle;
        bit head;
        bit e_ce;
        bit e_inr;
        bit n_active;
        bit n_clear;
        bit n_done;
        @(negedge clk);
        cyc++;
        rst = do_rst;
        if (do_rst) begin
            m_active = 1'b0; m_clear = 1'b0; m_done = 1'b0; m_chain = 1'b0;
            m_last_vld = 1'b0; m_left = 0;
            fl_cnt.delete(); fl_last.delete();
        end
        head = (fl_cnt.size() > 0) && (fl_cnt[0] == 0);
        cmd_valid = cv; cmd_prec = cp; cmd_chain = cc; cmd_len = CW'(cl);
        case (ivm)
            0:       in_valid = 1'b1;
            1:       in_valid = cyc[0];
            default: in_valid = 1'($urandom % 2);
        endcase
        case (rrm)
            0: res_ready = 1'b1;
            1: res_ready = (($urandom % 4) != 0);
            2: begin
                res_ready = 1'b1;
                if (head && stalls < 2) begin
                    res_ready = 1'b0;
                    stalls++;
                end
            end
            default: res_ready = 1'b1;
        endcase
        idle  = !m_active && !m_done;
        e_ce  = m_active && !m_clear && !(head && !res_ready);
        e_inr = e_ce && (m_left > 0);
        #1;
        check("cmd_ready", cmd_ready, idle);
        check("busy", busy, !idle);
        check("done", done, m_done);
        check("sclr", sclr, m_clear);
        check("ce", ce, e_ce);
        check("in_ready", in_ready, e_inr);
        check("res_valid", res_valid, head);
        check("res_last", res_last, head && fl_last[0]);
        check("select_precision", select_precision, m_active ? sel_tab[m_prec] : 4'b0000);
        check("active_chain", active_chain, m_active && m_chain);
        if (!do_rst) begin
            n_active = m_active;
            n_clear  = 1'b0;
            n_done   = 1'b0;
            if (m_done) begin
                m_last_prec = m_prec;
                m_last_vld  = 1'b1;
            end else if (idle) begin
                if (cv) begin
                    acc_cyc = cyc;
                    m_prec = cp; m_chain = cc; m_left = cl;
                    if (cl == 0) begin
                        n_done = 1'b1;
                    end else begin
                        n_active = 1'b1;
                        n_clear  = !m_last_vld || (cp != m_last_prec) || cc;
                    end
                end
            end else if (m_active && !m_clear && e_ce) begin
                if (head) begin
                    void'(fl_cnt.pop_front());
                    void'(fl_last.pop_front());
                end
                foreach (fl_cnt[i]) fl_cnt[i]--;
                if (in_valid && e_inr) begin
                    fl_cnt.push_back(L - 1);
                    fl_last.push_back(m_left == 1);
                    m_left--;
                end
                if (m_left == 0 && fl_cnt.size() == 0) begin
                    n_active = 1'b0;
                    n_done   = 1'b1;
                end
            end
            m_active = n_active;
            m_clear  = n_clear;
            m_done   = n_done;
        end
    endtask

    // Issue one command from IDLE and run until done; lat is accept-to-done cycles.
    task automatic run_cmd(input logic [1:0] p, input bit c, input int len,
                           input int ivm, input int rrm, output int lat);
        int  n;
        bit  seen;
        lat = -1; stalls = 0; seen = 1'b0; n = 0;
        step(1'b1, p, c, len, ivm, rrm, 1'b0);
        check("accepted", acc_cyc, cyc);
        while (!seen && n < 300) begin
            step(1'b0, 2'($urandom), 1'($urandom), 7, ivm, rrm, 1'b0);
            n++;
            if (done === 1'b1) begin
                seen = 1'b1;
                lat  = cyc - acc_cyc;
            end
        end
        check("done_timeout", seen, 1'b1);
        step(1'b0, 2'b00, 1'b0, 0, ivm, rrm, 1'b0);
    endtask

    initial begin
        int lat;
        int n;
        step(1'b0, 2'b00, 1'b0, 0, 0, 0, 1'b1);
        step(1'b0, 2'b00, 1'b0, 0, 0, 0, 1'b1);
        check("reset_cmd_ready", cmd_ready, 1'b1);
        step(1'b0, 2'b00, 1'b0, 0, 0, 0, 1'b0);

        // First INT8 command forces a clear: 1 + 4 beats + L + 1.
        run_cmd(2'b00, 1'b0, 4, 0, 0, lat);
        check("lat_int8_first", lat, 1 + 4 + L + 1);
        run_cmd(2'b00, 1'b0, 2, 0, 0, lat);
        check("lat_int8_noclear", lat, 2 + L + 1);
        run_cmd(2'b10, 1'b0, 3, 0, 2, lat);
        check("lat_int32_stall", lat, 1 + 3 + L + 1 + 2);
        run_cmd(2'b10, 1'b0, 0, 0, 0, lat);
        check("lat_len0", lat, 1);
        run_cmd(2'b11, 1'b0, 5, 1, 0, lat);
        check("lat_all_toggle_range", (lat >= 5 + L + 1) && (lat <= 1 + 10 + L + 1), 1'b1);
        run_cmd(2'b11, 1'b1, 3, 0, 0, lat);
        check("lat_chain_clear", lat, 1 + 3 + L + 1);
        run_cmd(2'b01, 1'b0, 1, 0, 0, lat);
        check("lat_int16_len1", lat, 1 + 1 + L + 1);

        // Reset in RUN with two beats in flight, then same precision must clear again.
        step(1'b1, 2'b01, 1'b0, 6, 0, 0, 1'b0);
        n = 0;
        while (fl_cnt.size() < 2 && n < 20) begin
            step(1'b0, 2'b00, 1'b0, 0, 0, 0, 1'b0);
            n++;
        end
        check("inflight_two", fl_cnt.size(), 2);
        step(1'b0, 2'b00, 1'b0, 0, 0, 0, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_ce", ce, 1'b0);
        step(1'b0, 2'b00, 1'b0, 0, 0, 0, 1'b0);
        run_cmd(2'b01, 1'b0, 2, 0, 0, lat);
        check("lat_after_rst_clear", lat, 1 + 2 + L + 1);

        // Random traffic with ignored commands while busy and occasional resets.
        for (int k = 0; k < 3000; k++) begin
            step(1'($urandom % 2), 2'($urandom), 1'(($urandom % 4) == 0),
                 int'($urandom_range(0, 5)), 2, 1, (($urandom % 300) == 0));
        end
        step(1'b0, 2'b00, 1'b0, 0, 0, 0, 1'b1);
        step(1'b0, 2'b00, 1'b0, 0, 0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
